count_capture: RTL and testbench
================================

# count_capture

Downstream consumer of the 4-bit free-running counter. Snapshots the counter value on an external capture strobe and, optionally, on every wrap from MAX_VALUE to 0. Snapshots go into a small FIFO and drain through a valid/ready interface. Also reports dropped snapshots and FIFO occupancy.

## Interface
- WIDTH, 4, width of the counter value sampled on count_in
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- MAX_VALUE, 15, counter terminal value used for wrap detection
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state immediately
- count_in  input  WIDTH  counter output, sampled every posedge
- capture  input  1  single-cycle strobe; request a snapshot of count_in
- out_valid  output  1  FIFO head is valid
- out_ready  input  1  consumer accepts head when high with out_valid
- out_data  output  WIDTH+1  {wrap_flag, count}; FIFO head
- fill  output  log2(DEPTH)+1  current number of entries, 0..DEPTH
- drop_count  output  8  saturating count of rejected snapshots
- overflow  output  1  sticky; set on first drop, cleared only by reset

## Operation
- Wrap event: prev_valid && prev_count == MAX_VALUE && count_in == 0.
  - prev_count is the registered count_in from the previous cycle.
  - prev_valid is cleared by reset and set on the first posedge after reset, so no wrap is detected on the first cycle out of reset.
- Push request: capture || wrap event.
  - Both in the same cycle produce ONE entry: {1, count_in}.
  - Capture only: {0, count_in}.
  - Wrap only: {1, count_in}, which is {1, 0}.
- Pop: out_valid && out_ready. Head advances; fill decrements.
- Push while fill == DEPTH and no pop this cycle:
  - Entry discarded; FIFO contents unchanged.
  - drop_count increments, saturating at 255.
  - overflow set.
- Push while full with a pop in the same cycle: push accepted, no drop, fill stays DEPTH.
- Push and pop in the same cycle when non-empty: both take effect; fill unchanged.
- Push while empty: no bypass. Entry becomes visible the next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. fill is tracked as a separate counter, so full and empty are unambiguous.
- out_data is driven from the registered head entry. It holds stable while out_valid && !out_ready.
- Reset asserted mid-operation: FIFO is emptied immediately and all pending entries are lost. out_valid deasserts asynchronously.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, fill = 0, drop_count = 0, overflow = 0.
  - Internal: pointers = 0, prev_count = 0, prev_valid = 0.
- Latency:
  - capture sampled at posedge N → out_valid = 1 and out_data valid after posedge N (visible in cycle N+1).
  - fill updates at the same edge as the push or pop.
- drop_count and overflow update at the edge on which the drop occurs.
- Throughput: one push and one pop per cycle sustained.
- Once asserted, out_valid stays high until a pop or reset. The consumer may hold out_ready high continuously.

## Configuration
- COUNT_CAPTURE_WRAP_EN defined:
  - Wrap detection and the prev_count/prev_valid registers are compiled in.
  - Wrap events enqueue as described above.
- Not defined:
  - Only capture enqueues.
  - out_data[WIDTH] is tied to 0.
  - prev_count/prev_valid are not built.
  - All other behaviour is identical.

## Test plan
- Reset, then capture pulse with count_in = 7, out_ready = 0 → next cycle out_valid = 1, out_data = {0,7}, fill = 1. Holds stable for 5 cycles; pop with out_ready = 1 → fill = 0, out_valid = 0.
- (WRAP_EN) Drive count_in 13, 14, 15, 0, 1 with no capture → exactly one entry {1,0}. With capture asserted in the cycle count_in = 0 → still exactly one entry {1,0}.
- Fill the FIFO with captures of 1, 2, 3, 4 (out_ready = 0), then capture 5 → fill = 4, drop_count = 1, overflow = 1. Drain yields 1, 2, 3, 4 in order.
- FIFO full, capture of 9 in the same cycle as a pop → no drop. fill stays 4, and the tail entry is {0,9} after draining.
- 300 captures while full with no pops → drop_count = 255 (saturated), overflow = 1.
- Assert reset asynchronously mid-cycle with fill = 3 → out_valid, fill, drop_count, and overflow all go to 0 before the next edge. A wrap of 15→0 on the first cycle after reset release does not enqueue.

Source files
------------

// File: rtl/count_capture.sv
// Snapshot FIFO for a free-running counter: captures on strobe (and on MAX_VALUE->0 wrap
// when COUNT_CAPTURE_WRAP_EN is defined), drains over valid/ready, counts dropped snapshots.
module count_capture #(
    parameter  int WIDTH     = 4,
    parameter  int DEPTH     = 4,
    parameter  int MAX_VALUE = 15,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             capture,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_data,
    output logic [AW:0]      fill,
    output logic [7:0]       drop_count,
    output logic             overflow
);

    logic [WIDTH:0]   r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_fill;
    logic [7:0]       r_drop_count;
    logic             r_overflow;

    logic             w_wrap;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_wr_en;
    logic             w_drop;
    logic [WIDTH:0]   w_entry;

`ifdef COUNT_CAPTURE_WRAP_EN
    logic [WIDTH-1:0] r_prev_count;
    logic             r_prev_valid;

    // prev_valid masks the first cycle out of reset so a stale prev_count cannot fake a wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_count <= '0;
            r_prev_valid <= 1'b0;
        end else begin
            r_prev_count <= count_in;
            r_prev_valid <= 1'b1;
        end
    end

    assign w_wrap = r_prev_valid && (r_prev_count == WIDTH'(MAX_VALUE)) && (count_in == '0);
`else
    assign w_wrap = 1'b0;
`endif

    // A simultaneous capture and wrap collapse into one flagged entry.
    assign w_push  = capture || w_wrap;
    assign w_entry = {w_wrap, count_in};
    assign w_pop   = out_valid && out_ready;
    assign w_full  = (r_fill == (AW+1)'(DEPTH));
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else if (w_drop) begin
            if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 1'b1;
            r_overflow <= 1'b1;
        end
    end

    // Derived from registered fill so out_valid falls as soon as reset clears it.
    assign out_valid  = (r_fill != '0);
    assign out_data   = r_mem[r_rd_ptr];
    assign fill       = r_fill;
    assign drop_count = r_drop_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_count_capture.sv
// Directed bench for count_capture: reset, capture latency/hold, wrap, overflow,
// full push+pop, drop saturation, async reset mid-cycle.
module tb_count_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count_in;
    logic       capture;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_data;
    logic [2:0] fill;
    logic [7:0] drop_count;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    count_capture dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .capture    (capture),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fill       (fill),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        count_in  = 4'd0;
        capture   = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_fill", fill, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b0;
        step();

        // capture latency and hold while stalled
        count_in = 4'd7; capture = 1'b1;
        step();
        capture = 1'b0;
        chk("cap_valid", out_valid, 1);
        chk("cap_data", out_data, 7);
        chk("cap_fill", fill, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_data", out_data, 7);
            chk("hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop_fill", fill, 0);
        chk("pop_valid", out_valid, 0);

        // wrap sequence without capture
        for (int v = 13; v <= 17; v++) begin
            count_in = 4'(v);
            step();
        end
`ifdef COUNT_CAPTURE_WRAP_EN
        chk("wrap_fill", fill, 1);
        chk("wrap_data", out_data, 16);
`else
        chk("wrap_fill", fill, 0);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("wrap_drain", fill, 0);

        // wrap coincident with capture
        count_in = 4'd15; step();
        count_in = 4'd0; capture = 1'b1; step();
        capture = 1'b0; count_in = 4'd1; step();
        chk("wrapcap_fill", fill, 1);
`ifdef COUNT_CAPTURE_WRAP_EN
        chk("wrapcap_data", out_data, 16);
`else
        chk("wrapcap_data", out_data, 0);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("wrapcap_drain", fill, 0);

        // fill to DEPTH then overflow by one
        for (int v = 1; v <= 5; v++) begin
            count_in = 4'(v); capture = 1'b1;
            step();
        end
        capture = 1'b0;
        chk("ovf_fill", fill, 4);
        chk("ovf_drop", drop_count, 1);
        chk("ovf_flag", overflow, 1);
        out_ready = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            chk("ovf_order", out_data, v);
            step();
        end
        out_ready = 1'b0;
        chk("ovf_empty", fill, 0);

        // full: push with simultaneous pop is accepted
        for (int v = 1; v <= 4; v++) begin
            count_in = 4'(v); capture = 1'b1;
            step();
        end
        count_in = 4'd9; out_ready = 1'b1;
        step();
        capture = 1'b0; out_ready = 1'b0;
        chk("pp_fill", fill, 4);
        chk("pp_drop", drop_count, 1);
        out_ready = 1'b1;
        for (int v = 2; v <= 5; v++) begin
            chk("pp_order", out_data, (v == 5) ? 9 : v);
            step();
        end
        out_ready = 1'b0;
        chk("pp_empty", fill, 0);

        // drop counter saturation
        count_in = 4'd5; capture = 1'b1;
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 100; i++) step();
        chk("sat_mid", drop_count, 101);
        for (int i = 0; i < 200; i++) step();
        capture = 1'b0;
        chk("sat_drop", drop_count, 255);
        chk("sat_ovf", overflow, 1);
        chk("sat_fill", fill, 4);

        // async reset mid-cycle with fill = 3
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ar_pre_fill", fill, 3);
        count_in = 4'd15;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_fill", fill, 0);
        chk("ar_drop", drop_count, 0);
        chk("ar_ovf", overflow, 0);
        step();
        reset = 1'b0;
        count_in = 4'd0;
        step();
        count_in = 4'd1;
        step();
        chk("ar_nowrap_fill", fill, 0);
        chk("ar_nowrap_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
